fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of the immediate generator and decoder.

---
 rtl/fetch_unit_pkg.sv | 27 ++
 rtl/fetch_unit_if.sv | 28 ++
 rtl/fetch_unit_pc_reg.sv | 46 ++++
 rtl/fetch_unit.sv | 142 ++++++++++++++
 tb/tb_fetch_unit.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch state encoding, reset/NOP defaults and the address helpers used by the PC logic.
package fetch_unit_pkg;

  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;

  typedef enum logic [2:0] {
    FS_REQ,
    FS_WAIT,
    FS_OUT,
    FS_DROP,
    FS_HALT
  } fetch_state_t;

  // jalr semantics: the target's bit 0 is always discarded
  function automatic logic [ILEN-1:0] jalr_clear_lsb(input logic [ILEN-1:0] addr);
    return {addr[ILEN-1:1], 1'b0};
  endfunction

  function automatic logic is_word_misaligned(input logic [ILEN-1:0] addr);
    return addr[1];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory req/gnt + rvalid bus between the fetch stage and imem.
// The master modport is the fetch side; the slave modport is the memory side.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic            req;
  logic [ILEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [ILEN-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register with hold / pc+4 / redirect next-pc selection.
// Also reports whether the current redirect target is word-misaligned.
module fetch_pc_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [ILEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            advance,
  input  logic            redirect,
  input  logic [ILEN-1:0] redirect_pc,
  output logic [ILEN-1:0] pc,
  output logic            tgt_misaligned
);

  logic [ILEN-1:0] tgt;
  logic [ILEN-1:0] pc_d;
  logic [ILEN-1:0] pc_q;

  assign tgt            = jalr_clear_lsb(redirect_pc);
  assign tgt_misaligned = is_word_misaligned(tgt);

  // A misaligned redirect leaves the pc untouched; pc+4 wraps silently
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      if (!tgt_misaligned) begin
        pc_d = tgt;
      end
    end else if (advance) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch FSM, registered decode-side outputs and the misalign flag.
// One outstanding imem request at a time; redirects from execute override everything but reset.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ILEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [ILEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  fetch_unit_if.master    imem,
  input  logic            redirect,
  input  logic [ILEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] pc_o,
  output logic [ILEN-1:0] instr_o,
  output logic            fetch_misalign
);

  fetch_state_t    state_d, state_q;
  logic            instr_valid_d, instr_valid_q;
  logic [ILEN-1:0] pc_o_d, pc_o_q;
  logic [ILEN-1:0] instr_o_d, instr_o_q;
  logic            misalign_d, misalign_q;
  logic            drop_to_halt_d, drop_to_halt_q;

  logic [ILEN-1:0] pc;
  logic            tgt_misaligned;
  logic            advance;
  logic            outstanding;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk            (clk),
    .rst            (rst),
    .advance        (advance),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .pc             (pc),
    .tgt_misaligned (tgt_misaligned)
  );

  // A response is still owed if it was granted this cycle or has not yet returned
  assign outstanding = (state_q == FS_REQ  && imem.gnt)
                    || (state_q == FS_WAIT)
                    || (state_q == FS_DROP && !imem.rvalid);

  always_comb begin
    state_d        = state_q;
    instr_valid_d  = instr_valid_q;
    pc_o_d         = pc_o_q;
    instr_o_d      = instr_o_q;
    misalign_d     = misalign_q;
    drop_to_halt_d = drop_to_halt_q;
    advance        = 1'b0;

    if (redirect) begin
      instr_valid_d  = 1'b0;
      instr_o_d      = NOP_INSTR;
      misalign_d     = tgt_misaligned;
      drop_to_halt_d = tgt_misaligned && outstanding;
      if (outstanding) begin
        state_d = FS_DROP;
      end else if (tgt_misaligned) begin
        state_d = FS_HALT;
      end else begin
        state_d = FS_REQ;
      end
    end else begin
      unique case (state_q)
        FS_REQ: begin
          if (imem.gnt) begin
            state_d = FS_WAIT;
          end
        end
        FS_WAIT: begin
          if (imem.rvalid) begin
            instr_o_d     = imem.rdata;
            pc_o_d        = pc;
            instr_valid_d = 1'b1;
            state_d       = FS_OUT;
          end
        end
        FS_OUT: begin
          if (instr_ready) begin
            advance       = 1'b1;
            instr_valid_d = 1'b0;
            instr_o_d     = NOP_INSTR;
            state_d       = FS_REQ;
          end
        end
        FS_DROP: begin
          if (imem.rvalid) begin
            state_d        = drop_to_halt_q ? FS_HALT : FS_REQ;
            drop_to_halt_d = 1'b0;
          end
        end
        FS_HALT: begin
          state_d = FS_HALT;
        end
        default: begin
          state_d = FS_REQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= FS_REQ;
      instr_valid_q  <= 1'b0;
      pc_o_q         <= RESET_PC;
      instr_o_q      <= NOP_INSTR;
      misalign_q     <= 1'b0;
      drop_to_halt_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      instr_valid_q  <= instr_valid_d;
      pc_o_q         <= pc_o_d;
      instr_o_q      <= instr_o_d;
      misalign_q     <= misalign_d;
      drop_to_halt_q <= drop_to_halt_d;
    end
  end

  // Request is suppressed during the reset cycle itself, then asserted from REQ
  assign imem.req  = (state_q == FS_REQ) && !rst;
  assign imem.addr = pc;

  assign instr_valid    = instr_valid_q;
  assign pc_o           = pc_o_q;
  assign instr_o        = instr_o_q;
  assign fetch_misalign = misalign_q;

  a_rvalid_only_when_owed: assert property (
    @(posedge clk) disable iff (rst)
    imem.rvalid |-> (state_q == FS_WAIT || state_q == FS_DROP)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table-driven startup sequence, scoreboard of consumed
// instructions, and hand-written stall / redirect / misalign / wrap / reset sequences.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        fetch_misalign;

  always #5 clk = ~clk;

  fetch_unit_if imem ();

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (imem),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .pc_o           (pc_o),
    .instr_o        (instr_o),
    .fetch_misalign (fetch_misalign)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h1234, 16'hC0DE};
  endfunction

  // Memory model: one response per grant, lat cycles after the grant, dropped on rst
  int          lat = 1;
  logic        force_dead = 1'b0;
  logic        busy = 1'b0;
  int          cnt = 0;
  logic [31:0] raddr = 32'h0;

  assign imem.gnt    = imem.req && !busy;
  assign imem.rvalid = busy && (cnt == 0);
  assign imem.rdata  = (busy && cnt == 0) ? (force_dead ? 32'hDEAD_BEEF : mem_word(raddr)) : 32'h0;

  always @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
    end else if (busy) begin
      if (cnt == 0) busy <= 1'b0;
      else          cnt  <= cnt - 1;
    end else if (imem.req && imem.gnt) begin
      busy  <= 1'b1;
      cnt   <= lat - 1;
      raddr <= imem.addr;
    end
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb_q[$];

  task automatic push_exp(input logic [31:0] p);
    exp_t e;
    e.pc    = p;
    e.instr = mem_word(p);
    sb_q.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic [31:0] rpc, input logic rdy);
    redirect    = rd;
    redirect_pc = rpc;
    instr_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_for_valid(input string name);
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        seen = 1;
        break;
      end
      step();
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("[TB] FAIL %s: instr_valid never rose within 40 cycles", name);
    end
  endtask

  task automatic wait_for_req(input string name, input logic [31:0] exp_addr);
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem.req) begin
        seen = 1;
        break;
      end
      step();
    end
    if (seen) begin
      checkOutput(name, imem.addr, exp_addr);
    end else begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s: no imem_req within 40 cycles, expected addr %h", name, exp_addr);
    end
  endtask

  // Monitor: every consumed instruction must match the scoreboard; idle output must be NOP
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst === 1'b0) begin
      if (instr_valid && instr_ready && !redirect) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL sb_unexpected: consumed pc %h instr %h with nothing expected", pc_o, instr_o);
        end else begin
          e = sb_q.pop_front();
          checkOutput("sb_pc", pc_o, e.pc);
          checkOutput("sb_instr", instr_o, e.instr);
        end
      end
      if (!instr_valid) begin
        checkOutput("nop_when_idle", instr_o, NOP_INSTR_DEF);
      end
    end
  end

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  vec_t vec[10];

  initial begin
    vec[0] = '{1'b0, 32'h0, 1'b0, 32'h0};
    vec[1] = '{1'b1, 32'h0, 1'b0, 32'h0};
    vec[2] = '{1'b0, 32'h0, 1'b0, 32'h0};
    vec[3] = '{1'b0, 32'h0, 1'b1, 32'h0};
    vec[4] = '{1'b1, 32'h4, 1'b0, 32'h0};
    vec[5] = '{1'b0, 32'h0, 1'b0, 32'h0};
    vec[6] = '{1'b0, 32'h0, 1'b1, 32'h4};
    vec[7] = '{1'b1, 32'h8, 1'b0, 32'h0};
    vec[8] = '{1'b0, 32'h0, 1'b0, 32'h0};
    vec[9] = '{1'b0, 32'h0, 1'b1, 32'h8};

    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1);
    push_exp(32'h0);
    push_exp(32'h4);
    push_exp(32'h8);
    step();

    // Startup: two reset cycles, then fetches at cycles 1, 4, 7
    for (int k = 0; k < 10; k++) begin
      if (k == 1) rst = 1'b0;
      @(negedge clk);
      checkOutput($sformatf("t1_req_k%0d", k), {31'b0, imem.req}, {31'b0, vec[k].req});
      checkOutput($sformatf("t1_valid_k%0d", k), {31'b0, instr_valid}, {31'b0, vec[k].valid});
      if (vec[k].req)   checkOutput($sformatf("t1_addr_k%0d", k), imem.addr, vec[k].addr);
      if (vec[k].valid) checkOutput($sformatf("t1_pc_k%0d", k), pc_o, vec[k].pc);
      if (k == 0)       checkOutput("t1_reset_misalign", {31'b0, fetch_misalign}, 32'h0);
      step();
    end

    // Stall in OUT for 5 cycles
    applyStimulus(1'b0, 32'h0, 1'b0);
    push_exp(32'hC);
    wait_for_valid("t2_valid");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput("t2_stall_valid", {31'b0, instr_valid}, 32'h1);
      checkOutput("t2_stall_pc", pc_o, 32'hC);
      checkOutput("t2_stall_instr", instr_o, mem_word(32'hC));
      checkOutput("t2_stall_noreq", {31'b0, imem.req}, 32'h0);
      step();
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    wait_for_req("t2_next_addr", 32'h10);

    // Redirect in WAIT; the late DEADBEEF response must be discarded
    lat = 2;
    force_dead = 1'b1;
    step();
    applyStimulus(1'b1, 32'h100, 1'b1);
    @(negedge clk);
    checkOutput("t3_wait_valid", {31'b0, instr_valid}, 32'h0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("t3_drop_instr", instr_o, NOP_INSTR_DEF);
    checkOutput("t3_drop_noreq", {31'b0, imem.req}, 32'h0);
    step();
    force_dead = 1'b0;
    lat = 1;
    push_exp(32'h100);
    wait_for_req("t3_redirect_addr", 32'h100);
    wait_for_valid("t3_valid");

    // Misaligned redirect while a response is owed: DROP then HALT
    step();
    applyStimulus(1'b1, 32'h202, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("t4_misalign_set", {31'b0, fetch_misalign}, 32'h1);
    checkOutput("t4_drop_valid", {31'b0, instr_valid}, 32'h0);
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t4_halt_noreq", {31'b0, imem.req}, 32'h0);
      checkOutput("t4_halt_misalign", {31'b0, fetch_misalign}, 32'h1);
      step();
    end
    applyStimulus(1'b1, 32'h200, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 1'b1);
    push_exp(32'h200);
    @(negedge clk);
    checkOutput("t4_misalign_clear", {31'b0, fetch_misalign}, 32'h0);
    checkOutput("t4_req", {31'b0, imem.req}, 32'h1);
    checkOutput("t4_addr", imem.addr, 32'h200);
    wait_for_valid("t4_valid");

    // jalr odd target and top-of-memory wrap
    step();
    applyStimulus(1'b1, 32'h41, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("t5_jalr_no_misalign", {31'b0, fetch_misalign}, 32'h0);
    push_exp(32'h40);
    wait_for_req("t5_jalr_addr", 32'h40);
    wait_for_valid("t5_jalr_valid");
    step();
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 1'b1);
    push_exp(32'hFFFF_FFFC);
    wait_for_req("t5_top_addr", 32'hFFFF_FFFC);
    wait_for_valid("t5_top_valid");
    wait_for_req("t5_wrap_addr", 32'h0);

    // Redirect and instr_ready together in OUT: redirect wins
    step();
    step();
    applyStimulus(1'b1, 32'h300, 1'b1);
    @(negedge clk);
    checkOutput("t6_out_valid", {31'b0, instr_valid}, 32'h1);
    checkOutput("t6_out_pc", pc_o, 32'h0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b1);
    wait_for_req("t6_redirect_wins", 32'h300);

    // Reset while waiting on a response
    lat = 3;
    step();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t6_rst_noreq", {31'b0, imem.req}, 32'h0);
    step();
    rst = 1'b0;
    lat = 1;
    @(negedge clk);
    checkOutput("t6_rst_req", {31'b0, imem.req}, 32'h1);
    checkOutput("t6_rst_addr", imem.addr, RESET_PC_DEF);
    checkOutput("t6_rst_valid", {31'b0, instr_valid}, 32'h0);
    checkOutput("t6_rst_misalign", {31'b0, fetch_misalign}, 32'h0);
    push_exp(32'h0);
    wait_for_valid("t6_rst_refetch");

    step();
    applyStimulus(1'b0, 32'h0, 1'b0);
    step();
    step();
    checkOutput("sb_empty", sb_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
